// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 round sequencer: steps the permutation datapath one round per
// cycle through init, AD absorption, PT encryption and finalisation.
module ascon_ctrl_fsm #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic       o_sys_enable,
  output logic       o_mux_select,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_enable_state_reg,
  output logic       o_enable_cipher_reg,
  output logic       o_enable_tag_reg,
  output logic [3:0] o_round,
  output logic       o_cipher_valid,
  output logic       o_done,
  output logic       o_busy
);

  localparam logic [3:0] RA_START   = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RB_START   = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT_AD = 3'd2,
    S_AD      = 3'd3,
    S_WAIT_PT = 3'd4,
    S_PT      = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       cipher_valid_q;
  logic       done_q;
  logic       start_s;
  logic       last_round_s;

  // Start is masked while reset is asserted so every output is 0 in reset.
  assign start_s      = i_start & reset_n;
  assign last_round_s = (cnt_q == LAST_ROUND);

  // Next-state, counter and control decode from state, counter and handshake.
  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    last_d                  = last_q;
    o_data_ready            = 1'b0;
    o_sys_enable            = 1'b0;
    o_mux_select            = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_state_reg      = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_round                 = cnt_q;
    o_busy                  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          // The start cycle itself is init round 0, loading the external state.
          o_sys_enable       = 1'b1;
          o_enable_state_reg = 1'b1;
          o_round            = RA_START;
          cnt_d              = RA_START + 4'd1;
          last_d             = 1'b0;
          state_d            = S_INIT;
        end else begin
          cnt_d = 4'd0;
        end
      end
      S_INIT, S_AD, S_PT, S_FINAL: begin
        o_sys_enable       = 1'b1;
        o_mux_select       = 1'b1;
        o_enable_state_reg = 1'b1;
        if (last_round_s) begin
          case (state_q)
            S_INIT: begin
              o_enable_xor_key_end = 1'b1;
              state_d              = S_WAIT_AD;
            end
            S_AD: begin
              // Domain separation after the final AD block.
              o_enable_xor_lsb_end = last_q;
              state_d              = last_q ? S_WAIT_PT : S_WAIT_AD;
            end
            S_PT: begin
              state_d = S_WAIT_PT;
            end
            default: begin
              o_enable_xor_key_end = 1'b1;
              o_enable_tag_reg     = 1'b1;
              cnt_d                = 4'd0;
              state_d              = S_DONE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT_AD, S_WAIT_PT: begin
        // Waiting keeps the state register frozen and the round index held.
        o_data_ready = 1'b1;
        o_sys_enable = 1'b1;
        o_mux_select = 1'b1;
        if (i_data_valid) begin
          o_enable_xor_data_begin = 1'b1;
          o_enable_state_reg      = 1'b1;
          if (state_q == S_WAIT_AD) begin
            o_round = RB_START;
            cnt_d   = RB_START + 4'd1;
            last_d  = i_data_last;
            state_d = S_AD;
          end else if (i_data_last) begin
            // Last PT block goes straight into the finalisation permutation.
            o_enable_cipher_reg    = 1'b1;
            o_enable_xor_key_begin = 1'b1;
            o_round                = RA_START;
            cnt_d                  = RA_START + 4'd1;
            state_d                = S_FINAL;
          end else begin
            o_enable_cipher_reg = 1'b1;
            o_round             = RB_START;
            cnt_d               = RB_START + 4'd1;
            state_d             = S_PT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, round counter and AD-last flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Registered strobes: cipher valid follows a cipher load, done marks DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cipher_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      cipher_valid_q <= o_enable_cipher_reg;
      done_q         <= (state_d == S_DONE);
    end
  end

  assign o_cipher_valid = cipher_valid_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm: directed vector table, hand-written
// corner sequences and random stimulus against a round-queue reference model.
module tb_ascon_ctrl_fsm;

  localparam int RA = 12;
  localparam int RB = 6;
  localparam int P_IDLE = 0;
  localparam int P_WAD  = 1;
  localparam int P_WPT  = 2;
  localparam int P_DONE = 3;

  typedef struct packed {
    logic       rdy, sys, mux, kb, db, ke, le, sr, cr, tr;
    logic [3:0] rnd;
    logic       cv, dn, bsy;
  } out_t;

  typedef struct {
    logic start, valid, last;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [3:0] round;
    logic       mux0, kb, db, cr, ke, le, tr;
  } rnd_t;

  logic       clock, reset_n, i_start, i_data_valid, i_data_last;
  logic       o_data_ready, o_sys_enable, o_mux_select;
  logic       o_enable_xor_key_begin, o_enable_xor_data_begin;
  logic       o_enable_xor_key_end, o_enable_xor_lsb_end;
  logic       o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg;
  logic [3:0] o_round;
  logic       o_cipher_valid, o_done, o_busy;
  out_t       act_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: pending rounds plus the phase after they drain.
  rnd_t       m_q[$];
  int         m_phase = P_IDLE;
  int         m_next  = P_IDLE;
  logic [3:0] m_held  = 4'd0;
  logic       m_prev_cr = 1'b0;

  ascon_ctrl_fsm #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clock(clock), .reset_n(reset_n), .i_start(i_start),
    .i_data_valid(i_data_valid), .i_data_last(i_data_last),
    .o_data_ready(o_data_ready), .o_sys_enable(o_sys_enable),
    .o_mux_select(o_mux_select),
    .o_enable_xor_key_begin(o_enable_xor_key_begin),
    .o_enable_xor_data_begin(o_enable_xor_data_begin),
    .o_enable_xor_key_end(o_enable_xor_key_end),
    .o_enable_xor_lsb_end(o_enable_xor_lsb_end),
    .o_enable_state_reg(o_enable_state_reg),
    .o_enable_cipher_reg(o_enable_cipher_reg),
    .o_enable_tag_reg(o_enable_tag_reg),
    .o_round(o_round), .o_cipher_valid(o_cipher_valid),
    .o_done(o_done), .o_busy(o_busy)
  );

  assign act_s = {o_data_ready, o_sys_enable, o_mux_select,
                  o_enable_xor_key_begin, o_enable_xor_data_begin,
                  o_enable_xor_key_end, o_enable_xor_lsb_end,
                  o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg,
                  o_round, o_cipher_valid, o_done, o_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase   = P_IDLE;
    m_next    = P_IDLE;
    m_held    = 4'd0;
    m_prev_cr = 1'b0;
  endtask

  // Queue one permutation: rounds first..11 with flags on its first/last round.
  task automatic push_block(input int first, input logic mux0, kb, db, cr,
                            input logic ke_end, le_end, tr_end);
    for (int r = first; r < 12; r++) begin
      rnd_t e;
      e = '0;
      e.round = 4'(r);
      if (r == first) begin
        e.mux0 = mux0; e.kb = kb; e.db = db; e.cr = cr;
      end
      if (r == 11) begin
        e.ke = ke_end; e.le = le_end; e.tr = tr_end;
      end
      m_q.push_back(e);
    end
  endtask

  // Expected outputs of the current cycle given its inputs; advances the model.
  task automatic model_eval(input logic s, v, l, output out_t e);
    rnd_t r;
    e    = '0;
    e.cv = m_prev_cr;
    if (m_q.size() == 0) begin
      case (m_phase)
        P_IDLE: begin
          if (s) begin
            push_block(12 - RA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            m_next = P_WAD;
          end
        end
        P_WAD, P_WPT: begin
          e.rdy = 1'b1; e.sys = 1'b1; e.mux = 1'b1; e.bsy = 1'b1; e.rnd = m_held;
          if (v) begin
            if (m_phase == P_WAD) begin
              push_block(12 - RB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, l, 1'b0);
              m_next = l ? P_WPT : P_WAD;
            end else if (l) begin
              push_block(12 - RA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
              m_next = P_DONE;
            end else begin
              push_block(12 - RB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
              m_next = P_WPT;
            end
          end
        end
        P_DONE: begin
          e.dn = 1'b1; e.bsy = 1'b1; m_phase = P_IDLE;
        end
        default: ;
      endcase
    end
    if (m_q.size() != 0) begin
      r = m_q.pop_front();
      e.sys = 1'b1; e.sr = 1'b1; e.mux = !r.mux0; e.bsy = !r.mux0;
      e.kb = r.kb; e.db = r.db; e.cr = r.cr; e.ke = r.ke; e.le = r.le; e.tr = r.tr;
      e.rnd = r.round;
      m_held = r.round;
      if (m_q.size() == 0) m_phase = m_next;
    end
    m_prev_cr = e.cr;
  endtask

  // One clock cycle: drive at negedge, compare #1 later against table or model.
  task automatic step(input logic s, v, l, input logic use_tab, input out_t tab_exp);
    out_t m;
    @(negedge clock);
    i_start = s; i_data_valid = v; i_data_last = l;
    model_eval(s, v, l, m);
    #1;
    if (use_tab) check("table", 32'(act_s), 32'(tab_exp));
    else         check("model", 32'(act_s), 32'(m));
    cyc++;
  endtask

  task automatic mstep(input logic s, v, l);
    step(s, v, l, 1'b0, '0);
  endtask

  function automatic out_t rnd_out(input int r);
    out_t o;
    o = '0;
    o.sys = 1'b1; o.mux = 1'b1; o.sr = 1'b1; o.bsy = 1'b1; o.rnd = 4'(r);
    return o;
  endfunction

  initial begin
    vec_t tab[37];
    int   lsb_cnt, cv_cnt, done_at;

    reset_n = 1'b0; i_start = 1'b0; i_data_valid = 1'b0; i_data_last = 1'b0;
    model_reset();

    // Directed table: 5 idle cycles after reset, then 1 AD + 1 last PT block.
    for (int i = 0; i < 37; i++) begin
      tab[i].start = 1'b0; tab[i].valid = 1'b0; tab[i].last = 1'b0; tab[i].exp = '0;
    end
    for (int c = 0; c < 32; c++) begin
      int k;
      k = c + 5;
      if (c == 0) begin
        tab[k].start = 1'b1;
        tab[k].exp = rnd_out(0); tab[k].exp.mux = 1'b0; tab[k].exp.bsy = 1'b0;
      end else if (c <= 11) begin
        tab[k].exp = rnd_out(c); tab[k].exp.ke = (c == 11);
      end else if (c <= 17) begin
        tab[k].exp = rnd_out(c - 6);
        tab[k].exp.le = (c == 17);
        if (c == 12) begin
          tab[k].valid = 1'b1; tab[k].last = 1'b1;
          tab[k].exp.rdy = 1'b1; tab[k].exp.db = 1'b1;
        end
      end else if (c <= 29) begin
        tab[k].exp = rnd_out(c - 18);
        tab[k].exp.cv = (c == 19);
        tab[k].exp.ke = (c == 29); tab[k].exp.tr = (c == 29);
        if (c == 18) begin
          tab[k].valid = 1'b1; tab[k].last = 1'b1;
          tab[k].exp.rdy = 1'b1; tab[k].exp.db = 1'b1;
          tab[k].exp.kb = 1'b1; tab[k].exp.cr = 1'b1;
        end
      end else if (c == 30) begin
        tab[k].exp.dn = 1'b1; tab[k].exp.bsy = 1'b1;
      end
    end

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 37; i++) step(tab[i].start, tab[i].valid, tab[i].last, 1'b1, tab[i].exp);

    // 2 AD + 3 PT with valid held high: transfers land with zero bubbles.
    lsb_cnt = 0; cv_cnt = 0; done_at = -1;
    for (int t = 0; t < 50; t++) begin
      mstep(t == 0, t > 0, (t == 18) || (t == 36));
      lsb_cnt += int'(o_enable_xor_lsb_end);
      cv_cnt  += int'(o_cipher_valid);
      if (o_done) done_at = t;
    end
    check("b2b_lsb_end_count", 32'(lsb_cnt), 32'd1);
    check("b2b_cipher_valid_count", 32'(cv_cnt), 32'd3);
    check("b2b_done_cycle", 32'(done_at), 32'd48);

    // Valid withheld 4 cycles in WAIT_PT: state held, round held, ready high.
    for (int t = 0; t < 42; t++) begin
      mstep(t == 0, (t == 12) || (t == 22) || (t == 28), (t == 12) || (t == 28));
      if (t >= 18 && t <= 21)
        check("wait_hold", {o_enable_state_reg, o_round, o_data_ready}, {1'b0, 4'd11, 1'b1});
      if (t == 22)
        check("wait_resume", {o_enable_state_reg, o_round, o_enable_cipher_reg}, {1'b1, 4'd6, 1'b1});
    end

    // Start pulsed during PT and valid during INIT: both ignored.
    done_at = -1;
    for (int t = 0; t < 38; t++) begin
      mstep((t == 0) || (t >= 19 && t <= 23),
            (t >= 1 && t <= 12) || (t == 18) || (t == 24),
            (t >= 1 && t <= 12) || (t == 24));
      if (t == 5) check("init_ignores_valid", {o_round, o_data_ready}, {4'd5, 1'b0});
      if (o_done) done_at = t;
    end
    check("ignore_done_cycle", 32'(done_at), 32'd36);

    // Asynchronous reset during AD round 8, then a clean restart.
    for (int t = 0; t < 15; t++) mstep(t == 0, t == 12, 1'b0);
    check("pre_reset_round", 32'(o_round), 32'd8);
    #1 reset_n = 1'b0;
    #1 check("async_reset_outputs", 32'(act_s), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    mstep(1'b1, 1'b0, 1'b0);
    check("restart_round0", {o_mux_select, o_round, o_enable_state_reg}, {1'b0, 4'd0, 1'b1});
    for (int t = 1; t < 12; t++) mstep(1'b0, 1'b0, 1'b0);

    // Random stimulus against the reference model.
    for (int t = 0; t < 3000; t++)
      mstep($urandom_range(7) == 0, $urandom_range(1) == 1, $urandom_range(2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
